// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low hex glyph table and segment constants.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 7;

    // Active-low glyphs, bit order g,f,e,d,c,b,a.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_hex7_dec.sv
// Combinational nibble to active-low seven-segment decoder.
module seg_hex7_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex7(nib);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit common-anode display scanner with per-slot blanking,
// per-digit masking and an end-of-frame pulse. All outputs are registered.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV          = 100000,
    parameter int BLANK_CYCLES = 2,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   sel,
    output logic [7:0]              seg,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_done
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [3:0]            nib_l_reg;
    logic                  dp_l_reg;
    logic [NUM_DIGITS-1:0] sel_reg, sel_next;
    logic [7:0]            seg_reg, seg_next;
    logic [IW-1:0]         digit_idx_reg;
    logic                  frame_done_reg;

    logic [3:0]            nib_arr [NUM_DIGITS];
    logic [6:0]            hex_seg;
    logic                  slot_end, last_digit, drive;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign nib_arr[gi] = data[4*gi +: 4];
    end

    seg_hex7_dec u_dec (
        .nib (nib_l_reg),
        .seg (hex_seg)
    );

    always_comb begin
        slot_end   = (cnt_reg == CNT_LAST);
        last_digit = (idx_reg == IDX_LAST);
        drive      = (cnt_reg >= BLANK_END) && digit_en[idx_reg];
        cnt_next   = cnt_reg + CW'(1);
        idx_next   = idx_reg;
        if (slot_end) begin
            cnt_next = '0;
            idx_next = last_digit ? '0 : idx_reg + IW'(1);
        end
        seg_next = drive ? {~dp_l_reg, hex_seg} : SEG_BLANK;
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign sel_next[gi] = !(drive && (idx_reg == IW'(gi)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            nib_l_reg      <= '0;
            dp_l_reg       <= 1'b0;
            sel_reg        <= '1;
            seg_reg        <= SEG_BLANK;
            digit_idx_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else if (!enable) begin
            // Restart so the next enabled cycle opens digit 0 with a full blank phase.
            cnt_reg        <= '0;
            idx_reg        <= '0;
            sel_reg        <= '1;
            seg_reg        <= SEG_BLANK;
            digit_idx_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            // Latch the digit's glyph just before the drive phase so it is stable all slot.
            if (cnt_reg == BLANK_LAST) begin
                nib_l_reg <= nib_arr[idx_reg];
                dp_l_reg  <= dp[idx_reg];
            end
            sel_reg        <= sel_next;
            seg_reg        <= seg_next;
            digit_idx_reg  <= idx_reg;
            frame_done_reg <= slot_end && last_digit;
        end
    end

    assign sel        = sel_reg;
    assign seg        = seg_reg;
    assign digit_idx  = digit_idx_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed scenarios plus random traffic
// compared every cycle against a time-based reference model.
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [4*N-1:0] data = '0;
    logic [N-1:0]  dp = '0;
    logic [N-1:0]  digit_en = '0;
    logic [N-1:0]  sel;
    logic [7:0]    seg;
    logic [1:0]    digit_idx;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: t is the number of enabled cycles since the scan (re)started, mod one frame.
    int         t = 0;
    logic [3:0] m_nib = '0;
    logic       m_dp  = 1'b0;
    logic [6:0] hex_tab [16];

    seg_scan_driver #(
        .NUM_DIGITS   (N),
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data       (data),
        .dp         (dp),
        .digit_en   (digit_en),
        .sel        (sel),
        .seg        (seg),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: predict from current inputs and model time, then compare after the edge.
    task automatic step();
        logic [N-1:0] e_sel;
        logic [7:0]   e_seg;
        logic [1:0]   e_idx;
        logic         e_fd;
        int pos, di;
        e_sel = '1; e_seg = 8'hFF; e_idx = '0; e_fd = 1'b0;
        if (rst || !enable) begin
            t = 0;
        end else begin
            pos = t % DIV;
            di  = (t / DIV) % N;
            if (pos == BLANK - 1) begin
                m_nib = data[4*di +: 4];
                m_dp  = dp[di];
            end
            e_idx = 2'(di);
            e_fd  = (pos == DIV - 1) && (di == N - 1);
            if (pos >= BLANK && digit_en[di]) begin
                e_sel = ~(N'(1) << di);
                e_seg = {~m_dp, hex_tab[m_nib]};
            end
            t = (t + 1) % FRAME;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("sel", 32'(sel), 32'(e_sel));
        check("seg", 32'(seg), 32'(e_seg));
        check("digit_idx", 32'(digit_idx), 32'(e_idx));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        $display("cyc=%0d rst=%0b en=%0b sel=%b seg=%b idx=%0d fd=%0b", cyc, rst, enable, sel, seg, digit_idx, frame_done);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the DUT's internal slot position equals target (bounded).
    task automatic run_to(input int target);
        int k;
        k = 0;
        while (t != target && k < 4 * FRAME) begin
            step();
            k++;
        end
        if (t != target) check("run_to_timeout", 32'(t), 32'(target));
    endtask

    initial begin
        int fd_count;
        int k;
        hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        // Reset
        rst = 1'b1;
        steps(3);
        check("rst_sel", 32'(sel), 32'h0000_000F);
        check("rst_seg", 32'(seg), 32'h0000_00FF);
        rst = 1'b0;
        step();

        // Plain scan: two full frames, count frame pulses
        data = 16'h3A7F; dp = 4'h0; digit_en = 4'hF; enable = 1'b1;
        fd_count = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (frame_done) fd_count++;
            if (i == BLANK + 1) check("scan_seg_d0", 32'(seg), 32'h0000_008E);
        end
        check("scan_fd_count", 32'(fd_count), 32'd2);

        // Mask and decimal point
        data = 16'h8888; dp = 4'b0010; digit_en = 4'b1010;
        steps(2 * FRAME);

        // Mid-slot data change in slot 1
        data = 16'h3A5F; dp = 4'h0; digit_en = 4'hF;
        run_to(DIV + 4);
        data[7:4] = 4'h6;
        run_to(2 * DIV);
        check("midslot_hold", 32'(seg), 32'h0000_0092);
        run_to(DIV + 4);
        check("next_frame", 32'(seg), 32'h0000_0082);

        // Enable drop mid-slot
        run_to(2 * DIV + 5);
        enable = 1'b0;
        fd_count = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (frame_done) fd_count++;
        end
        check("drop_fd", 32'(fd_count), 32'd0);
        enable = 1'b1;
        steps(FRAME + 4);

        // Reset mid-scan, then confirm the first driven select is digit 0
        run_to(3 * DIV + 6);
        rst = 1'b1;
        step();
        check("midrst_sel", 32'(sel), 32'h0000_000F);
        rst = 1'b0;
        k = 0;
        step();
        while (sel == 4'hF && k < 2 * DIV) begin
            step();
            k++;
        end
        check("first_sel", 32'(sel), 32'h0000_000E);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) data = 16'($urandom);
            if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
            enable = ($urandom_range(0, 99) >= 3);
            rst    = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        enable = 1'b1;
        steps(FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
